// File: rtl/core_pkg.sv
// Shared types and constants for the MEM-stage load/store unit:
// FSM states, funct3 size codes and access-size decode helpers.
package core_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Unused codes (011/110/111) fall through to a full-word access.
  function automatic size_t accessSize(input logic [2:0] funct3);
    case (funct3)
      F3_BYTE, F3_BYTE_U: return SZ_BYTE;
      F3_HALF, F3_HALF_U: return SZ_HALF;
      default:            return SZ_WORD;
    endcase
  endfunction

  function automatic logic isMisaligned(input size_t sz, input logic [1:0] offset);
    case (sz)
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    case (offset_i)
      2'd0:    byteSel = rdata_i[7:0];
      2'd1:    byteSel = rdata_i[15:8];
      2'd2:    byteSel = rdata_i[23:16];
      default: byteSel = rdata_i[31:24];
    endcase
    halfSel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // funct3[2] marks the unsigned variants.
    case (accessSize(funct3_i))
      SZ_BYTE: data_o = funct3_i[2] ? {24'b0, byteSel} : {{24{byteSel[7]}}, byteSel};
      SZ_HALF: data_o = funct3_i[2] ? {16'b0, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one word-aligned bus access per instruction,
// stalls the pipeline until ack or timeout, and returns the aligned load value.
module mem_access_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead_MEM,
  input  logic        memWrite_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] ALUResult_MEM,
  input  logic [31:0] writeData_MEM,
  mem_access_unit_if.master dmem,
  output logic [31:0] loadOut_MEM,
  output logic        stall_MEM,
  output logic        misaligned_MEM,
  output logic        busError_MEM
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       offset_q, offset_d;
  logic             isLoad_q, isLoad_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busError_q, busError_d;

  size_t       reqSize;
  logic        accessReq, misalignedReq, startAccess, ackTaken, timeoutHit;
  logic [31:0] storeData;
  logic [3:0]  storeBe;
  logic [31:0] alignedLoad;

  // Request decode; rst_n gates the pending access so combinational outputs are 0 in reset.
  always_comb begin
    reqSize       = accessSize(funct3_MEM);
    accessReq     = rst_n && (memRead_MEM || memWrite_MEM);
    misalignedReq = isMisaligned(reqSize, ALUResult_MEM[1:0]);
    startAccess   = (state_q == IDLE) && accessReq && !misalignedReq;
    ackTaken      = (state_q == WAIT) && dmem.dmem_ack;
    timeoutHit    = (state_q == WAIT) && !dmem.dmem_ack && (cnt_q == CNT_LAST);
    case (reqSize)
      SZ_BYTE: begin
        storeData = {4{writeData_MEM[7:0]}};
        storeBe   = 4'b0001 << ALUResult_MEM[1:0];
      end
      SZ_HALF: begin
        storeData = {2{writeData_MEM[15:0]}};
        storeBe   = ALUResult_MEM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        storeData = writeData_MEM;
        storeBe   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startAccess) state_d = WAIT;
      WAIT:    if (ackTaken || timeoutHit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    funct3_d   = funct3_q;
    offset_d   = offset_q;
    isLoad_d   = isLoad_q;
    rdata_d    = rdata_q;
    cnt_d      = '0;
    busError_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (startAccess) begin
          req_d    = 1'b1;
          we_d     = memWrite_MEM;
          addr_d   = {ALUResult_MEM[31:2], 2'b00};
          wdata_d  = storeData;
          be_d     = storeBe;
          funct3_d = funct3_MEM;
          offset_d = ALUResult_MEM[1:0];
          isLoad_d = !memWrite_MEM;
        end
      end
      WAIT: begin
        if (ackTaken) begin
          req_d   = 1'b0;
          rdata_d = dmem.dmem_rdata;
        end else if (timeoutHit) begin
          req_d      = 1'b0;
          busError_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    stall_MEM      = startAccess || (state_q == WAIT);
    misaligned_MEM = (state_q == IDLE) && accessReq && misalignedReq;
    loadOut_MEM    = ((state_q == DONE) && isLoad_q && !busError_q) ? alignedLoad : 32'h0;
    busError_MEM   = busError_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      funct3_q   <= '0;
      offset_q   <= '0;
      isLoad_q   <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      busError_q <= 1'b0;
    end else begin
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      funct3_q   <= funct3_d;
      offset_q   <= offset_d;
      isLoad_q   <= isLoad_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      busError_q <= busError_d;
    end
  end

  load_align uLoadAlign (
    .rdata_i  (rdata_q),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .data_o   (alignedLoad)
  );

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short timeout so the bus-error path is reachable.
module tb_mem_access_unit;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] alu, wd;
  logic [31:0] loadOut;
  logic        stall, misaligned, busError;
  int          checks;
  int          errors;

  mem_access_unit_if busIf();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .memRead_MEM    (memRead),
    .memWrite_MEM   (memWrite),
    .funct3_MEM     (funct3),
    .ALUResult_MEM  (alu),
    .writeData_MEM  (wd),
    .dmem           (busIf.master),
    .loadOut_MEM    (loadOut),
    .stall_MEM      (stall),
    .misaligned_MEM (misaligned),
    .busError_MEM   (busError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b000; alu = 32'h0; wd = 32'h0;
    busIf.dmem_ack = 1'b0; busIf.dmem_rdata = 32'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idleInputs();
    #3;
    checks++; if (busIf.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b expected 0", busIf.dmem_req); end
    checks++; if (busIf.dmem_be !== 4'b0000) begin errors++; $display("[TB] FAIL reset_be got %b expected 0000", busIf.dmem_be); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b expected 0", stall); end
    checks++; if (loadOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_loadOut got %h expected 0", loadOut); end
    checks++; if (busError !== 1'b0) begin errors++; $display("[TB] FAIL reset_busError got %b expected 0", busError); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_byte;
    memRead = 1'b1; funct3 = F3_BYTE; alu = 32'h103;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lb_stall_idle got %b expected 1", stall); end
    checks++; if (busIf.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lb_req_idle got %b expected 0", busIf.dmem_req); end
    tick();
    checks++; if (busIf.dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL lb_req_wait got %b expected 1", busIf.dmem_req); end
    checks++; if (busIf.dmem_addr !== 32'h100) begin errors++; $display("[TB] FAIL lb_addr got %h expected 00000100", busIf.dmem_addr); end
    checks++; if (busIf.dmem_we !== 1'b0) begin errors++; $display("[TB] FAIL lb_we got %b expected 0", busIf.dmem_we); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lb_stall_wait1 got %b expected 1", stall); end
    tick();
    busIf.dmem_ack = 1'b1; busIf.dmem_rdata = 32'h80FF_FF12;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lb_stall_wait2 got %b expected 1", stall); end
    checks++; if (loadOut !== 32'h0) begin errors++; $display("[TB] FAIL lb_loadOut_wait got %h expected 0", loadOut); end
    tick();
    busIf.dmem_ack = 1'b0; memRead = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lb_stall_done got %b expected 0", stall); end
    checks++; if (busIf.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lb_req_done got %b expected 0", busIf.dmem_req); end
    checks++; if (loadOut !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL lb_loadOut got %h expected ffffff80", loadOut); end
    tick();
    checks++; if (loadOut !== 32'h0) begin errors++; $display("[TB] FAIL lb_loadOut_idle got %h expected 0", loadOut); end
  endtask

  task automatic test_store;
    // Halfword store in the upper lanes; bus must hold steady across an extra WAIT cycle.
    memWrite = 1'b1; funct3 = F3_HALF; alu = 32'h202; wd = 32'h0000_ABCD;
    tick();
    checks++; if (busIf.dmem_addr !== 32'h200) begin errors++; $display("[TB] FAIL sh_addr got %h expected 00000200", busIf.dmem_addr); end
    checks++; if (busIf.dmem_be !== 4'b1100) begin errors++; $display("[TB] FAIL sh_be got %b expected 1100", busIf.dmem_be); end
    checks++; if (busIf.dmem_wdata !== 32'hABCD_ABCD) begin errors++; $display("[TB] FAIL sh_wdata got %h expected abcdabcd", busIf.dmem_wdata); end
    checks++; if (busIf.dmem_we !== 1'b1) begin errors++; $display("[TB] FAIL sh_we got %b expected 1", busIf.dmem_we); end
    tick();
    checks++; if (busIf.dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL sh_req_hold got %b expected 1", busIf.dmem_req); end
    checks++; if (busIf.dmem_addr !== 32'h200) begin errors++; $display("[TB] FAIL sh_addr_hold got %h expected 00000200", busIf.dmem_addr); end
    busIf.dmem_ack = 1'b1;
    tick();
    busIf.dmem_ack = 1'b0; memWrite = 1'b0;
    checks++; if (loadOut !== 32'h0) begin errors++; $display("[TB] FAIL sh_loadOut got %h expected 0", loadOut); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL sh_stall_done got %b expected 0", stall); end
    tick();

    memWrite = 1'b1; funct3 = F3_BYTE; alu = 32'h001; wd = 32'h1234_5678;
    tick();
    checks++; if (busIf.dmem_wdata !== 32'h7878_7878) begin errors++; $display("[TB] FAIL sb_wdata got %h expected 78787878", busIf.dmem_wdata); end
    checks++; if (busIf.dmem_be !== 4'b0010) begin errors++; $display("[TB] FAIL sb_be got %b expected 0010", busIf.dmem_be); end
    busIf.dmem_ack = 1'b1;
    tick();
    busIf.dmem_ack = 1'b0; memWrite = 1'b0;
    tick();

    // Read and write both asserted resolves to a write.
    memRead = 1'b1; memWrite = 1'b1; funct3 = F3_WORD; alu = 32'h004; wd = 32'hDEAD_BEEF;
    tick();
    checks++; if (busIf.dmem_we !== 1'b1) begin errors++; $display("[TB] FAIL sw_both_we got %b expected 1", busIf.dmem_we); end
    checks++; if (busIf.dmem_be !== 4'b1111) begin errors++; $display("[TB] FAIL sw_be got %b expected 1111", busIf.dmem_be); end
    checks++; if (busIf.dmem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sw_wdata got %h expected deadbeef", busIf.dmem_wdata); end
    busIf.dmem_ack = 1'b1; busIf.dmem_rdata = 32'h5555_5555;
    tick();
    busIf.dmem_ack = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    checks++; if (loadOut !== 32'h0) begin errors++; $display("[TB] FAIL sw_both_loadOut got %h expected 0", loadOut); end
    tick();
  endtask

  task automatic test_misaligned;
    memRead = 1'b1; funct3 = F3_WORD; alu = 32'h101;
    #1;
    checks++; if (misaligned !== 1'b1) begin errors++; $display("[TB] FAIL lw_mis_flag got %b expected 1", misaligned); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lw_mis_stall got %b expected 0", stall); end
    tick();
    checks++; if (busIf.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lw_mis_req got %b expected 0", busIf.dmem_req); end
    checks++; if (loadOut !== 32'h0) begin errors++; $display("[TB] FAIL lw_mis_loadOut got %h expected 0", loadOut); end
    checks++; if (misaligned !== 1'b1) begin errors++; $display("[TB] FAIL lw_mis_stays got %b expected 1", misaligned); end
    funct3 = F3_HALF; alu = 32'h003;
    #1;
    checks++; if (misaligned !== 1'b1) begin errors++; $display("[TB] FAIL lh_mis_flag got %b expected 1", misaligned); end
    funct3 = F3_HALF_U; alu = 32'h002;
    #1;
    checks++; if (misaligned !== 1'b0) begin errors++; $display("[TB] FAIL lhu_aligned_flag got %b expected 0", misaligned); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lhu_aligned_stall got %b expected 1", stall); end
    memRead = 1'b0;
    tick();
    checks++; if (busIf.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_idle_req got %b expected 0", busIf.dmem_req); end
  endtask

  task automatic test_timeout;
    memRead = 1'b1; funct3 = F3_WORD; alu = 32'h010;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (busIf.dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL to_req_wait%0d got %b expected 1", i, busIf.dmem_req); end
      checks++; if (busError !== 1'b0) begin errors++; $display("[TB] FAIL to_busError_wait%0d got %b expected 0", i, busError); end
    end
    tick();
    checks++; if (busIf.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL to_req_drop got %b expected 0", busIf.dmem_req); end
    checks++; if (busError !== 1'b1) begin errors++; $display("[TB] FAIL to_busError_pulse got %b expected 1", busError); end
    checks++; if (loadOut !== 32'h0) begin errors++; $display("[TB] FAIL to_loadOut got %h expected 0", loadOut); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL to_stall_done got %b expected 0", stall); end
    memRead = 1'b0; busIf.dmem_ack = 1'b1;
    tick();
    checks++; if (busError !== 1'b0) begin errors++; $display("[TB] FAIL to_busError_once got %b expected 0", busError); end
    tick();
    checks++; if (busIf.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack_ignored got %b expected 0", busIf.dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack_stall got %b expected 0", stall); end
    busIf.dmem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait;
    memRead = 1'b1; funct3 = F3_WORD; alu = 32'h020;
    tick();
    checks++; if (busIf.dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_req got %b expected 1", busIf.dmem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busIf.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_req got %b expected 0", busIf.dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_stall got %b expected 0", stall); end
    checks++; if (busIf.dmem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_addr got %h expected 0", busIf.dmem_addr); end
    memRead = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    memRead = 1'b1; funct3 = F3_HALF_U; alu = 32'h002;
    tick();
    busIf.dmem_ack = 1'b1; busIf.dmem_rdata = 32'hF00D_0000;
    tick();
    busIf.dmem_ack = 1'b0; memRead = 1'b0;
    checks++; if (loadOut !== 32'h0000_F00D) begin errors++; $display("[TB] FAIL rst_lhu_loadOut got %h expected 0000f00d", loadOut); end
    tick();
  endtask

  task automatic test_load_variants;
    logic [31:0] addrs [6];
    logic [2:0]  f3s   [6];
    logic [31:0] words [6];
    logic [31:0] exps  [6];
    addrs[0] = 32'h103; f3s[0] = F3_BYTE_U; words[0] = 32'h80FF_FF12; exps[0] = 32'h0000_0080;
    addrs[1] = 32'h002; f3s[1] = F3_HALF;   words[1] = 32'hF00D_0000; exps[1] = 32'hFFFF_F00D;
    addrs[2] = 32'h100; f3s[2] = F3_BYTE;   words[2] = 32'h80FF_FF12; exps[2] = 32'h0000_0012;
    addrs[3] = 32'h104; f3s[3] = F3_WORD;   words[3] = 32'h80FF_FF12; exps[3] = 32'h80FF_FF12;
    addrs[4] = 32'h108; f3s[4] = 3'b011;    words[4] = 32'h1234_5678; exps[4] = 32'h1234_5678;
    addrs[5] = 32'h000; f3s[5] = F3_HALF_U; words[5] = 32'h80FF_FF12; exps[5] = 32'h0000_FF12;
    for (int i = 0; i < 6; i++) begin
      memRead = 1'b1; funct3 = f3s[i]; alu = addrs[i];
      tick();
      busIf.dmem_ack = 1'b1; busIf.dmem_rdata = words[i];
      tick();
      busIf.dmem_ack = 1'b0; memRead = 1'b0;
      checks++; if (loadOut !== exps[i]) begin errors++; $display("[TB] FAIL load_var%0d got %h expected %h", i, loadOut, exps[i]); end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_byte();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_load_variants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
